// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the program counter, reads instruction memory, hands words
// to the decoder over valid/ready and applies jump/call/return/halt redirects.
module pc_sequencer #(
    parameter int              AW       = 8,
    parameter int              IW       = 8,
    parameter int              RS_DEPTH = 4,
    parameter logic [AW-1:0]   RESET_PC = 8'h00
) (
    input  logic                      CLK,
    input  logic                      areset,
    output logic                      imem_req,
    output logic [AW-1:0]             imem_addr,
    input  logic                      imem_ack,
    input  logic [IW-1:0]             imem_data,
    output logic                      instr_valid,
    output logic [IW-1:0]             instr,
    output logic [AW-1:0]             instr_pc,
    input  logic                      instr_ready,
    input  logic                      redir_valid,
    input  logic [1:0]                redir_type,
    input  logic [AW-1:0]             redir_target,
    output logic [$clog2(RS_DEPTH):0] rs_count,
    output logic                      rs_err,
    output logic                      halted
);

    localparam int PW = $clog2(RS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] RT_JUMP = 2'b00;
    localparam logic [1:0] RT_CALL = 2'b01;
    localparam logic [1:0] RT_RET  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_FLUSH,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   last_pc_q, last_pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [AW-1:0]   instr_pc_q, instr_pc_d;
    logic            halt_pend_q, halt_pend_d;
    logic [PW-1:0]   sp_q, sp_d;
    logic [CW-1:0]   rs_count_q, rs_count_d;
    logic            rs_err_q, rs_err_d;

    // Circular return stack; sp_q is the next free slot, which is also the oldest
    // entry once the stack is full, so a push on a full stack overwrites the oldest.
    logic [AW-1:0]   rs_mem [RS_DEPTH];
    logic [PW-1:0]   top_idx;
    logic            push_en;
    logic [AW-1:0]   push_data;
    logic            redir_take;
    logic            is_halt;

    assign top_idx    = sp_q - PW'(1);
    assign redir_take = redir_valid && (state_q == S_REQ || state_q == S_ISSUE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge CLK) begin
        if (areset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            last_pc_q   <= RESET_PC;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            halt_pend_q <= 1'b0;
            sp_q        <= '0;
            rs_count_q  <= '0;
            rs_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            last_pc_q   <= last_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            halt_pend_q <= halt_pend_d;
            sp_q        <= sp_d;
            rs_count_q  <= rs_count_d;
            rs_err_q    <= rs_err_d;
        end
    end

    // NOTE: stack storage has no reset; rs_count_q alone defines which entries are
    // valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge CLK) begin
        if (push_en && !areset) begin
            rs_mem[sp_q] <= push_data;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        last_pc_d   = last_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        halt_pend_d = halt_pend_q;
        sp_d        = sp_q;
        rs_count_d  = rs_count_q;
        rs_err_d    = rs_err_q;
        push_en     = 1'b0;
        push_data   = last_pc_q + AW'(1);
        is_halt     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack && !redir_take) begin
                    instr_d    = imem_data;
                    instr_pc_d = pc_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready && !redir_take) begin
                    last_pc_d = instr_pc_q;
                    pc_d      = pc_q + AW'(1);
                    state_d   = S_REQ;
                end
            end
            S_FLUSH: begin
                // The outstanding response is consumed and dropped.
                if (imem_ack) begin
                    state_d     = halt_pend_q ? S_HALT : S_REQ;
                    halt_pend_d = 1'b0;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Redirects override both the decoder handshake and the memory response.
        if (redir_take) begin
            case (redir_type)
                RT_JUMP: pc_d = redir_target;
                RT_CALL: begin
                    pc_d    = redir_target;
                    push_en = 1'b1;
                    sp_d    = sp_q + PW'(1);
                    if (rs_count_q == CW'(RS_DEPTH)) begin
                        rs_err_d = 1'b1;
                    end else begin
                        rs_count_d = rs_count_q + CW'(1);
                    end
                end
                RT_RET: begin
                    if (rs_count_q == '0) begin
                        pc_d     = redir_target;
                        rs_err_d = 1'b1;
                    end else begin
                        pc_d       = rs_mem[top_idx];
                        sp_d       = top_idx;
                        rs_count_d = rs_count_q - CW'(1);
                    end
                end
                default: is_halt = 1'b1;
            endcase

            if (state_q == S_REQ && !imem_ack) begin
                state_d     = S_FLUSH;
                halt_pend_d = is_halt;
            end else begin
                state_d = is_halt ? S_HALT : S_REQ;
            end
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = imem_req ? pc_q : '0;
    assign instr_valid = (state_q == S_ISSUE);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign rs_count    = rs_count_q;
    assign rs_err      = rs_err_q;
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-by-cycle vector table for fetch, stall,
// flush and call/return, plus hand-written overflow, wrap, halt and reset sequences.
module tb_pc_sequencer;

    localparam logic [1:0] RT_JUMP = 2'b00;
    localparam logic [1:0] RT_CALL = 2'b01;
    localparam logic [1:0] RT_RET  = 2'b10;
    localparam logic [1:0] RT_HALT = 2'b11;

    logic       CLK = 1'b0;
    logic       areset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       redir_valid;
    logic [1:0] redir_type;
    logic [7:0] redir_target;
    logic [2:0] rs_count;
    logic       rs_err;
    logic       halted;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_sequencer dut (
        .CLK          (CLK),
        .areset       (areset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .redir_valid  (redir_valid),
        .redir_type   (redir_type),
        .redir_target (redir_target),
        .rs_count     (rs_count),
        .rs_err       (rs_err),
        .halted       (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ack;
        logic [7:0] data;
        logic       rdy;
        logic       rv;
        logic [1:0] rt;
        logic [7:0] tgt;
        logic       req;
        logic [7:0] addr;
        logic       vld;
        logic [7:0] ins;
        logic [7:0] ipc;
        logic [2:0] cnt;
        logic       err;
        logic       hlt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic ack, input logic [7:0] data, input logic rdy,
                                input logic rv, input logic [1:0] rt, input logic [7:0] tgt,
                                input logic req, input logic [7:0] addr, input logic vld,
                                input logic [7:0] ins, input logic [7:0] ipc,
                                input logic [2:0] cnt, input logic err, input logic hlt);
        vec_t v;
        v.ack = ack; v.data = data; v.rdy = rdy; v.rv = rv; v.rt = rt; v.tgt = tgt;
        v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.ipc = ipc;
        v.cnt = cnt; v.err = err; v.hlt = hlt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic cyc(input logic rst, input logic ack, input logic [7:0] data,
                       input logic rdy, input logic rv, input logic [1:0] rt,
                       input logic [7:0] tgt);
        @(negedge CLK);
        areset       = rst;
        imem_ack     = ack;
        imem_data    = data;
        instr_ready  = rdy;
        redir_valid  = rv;
        redir_type   = rt;
        redir_target = tgt;
        #1;
    endtask

    // Leaves areset asserted; the next cyc() call releases it.
    task automatic do_reset;
        cyc(1, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        cyc(1, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
    endtask

    function automatic logic [30:0] outs();
        return {imem_req, imem_addr, instr_valid, instr, instr_pc, rs_count, rs_err, halted};
    endfunction

    logic [7:0] pops [5];
    logic [7:0] exp_addr;
    logic [7:0] tgt;

    initial begin
        //          ack data  rdy rv rt       tgt     req addr  vld ins    ipc  cnt err hlt
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tv.push_back(mk(1, 8'h11, 0, 0, RT_JUMP, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h11, 8'h00, 0, 0, 0));
        tv.push_back(mk(1, 8'h22, 0, 0, RT_JUMP, 8'h00, 1, 8'h01, 0, 8'h11, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h22, 8'h01, 0, 0, 0));
        tv.push_back(mk(1, 8'h33, 0, 0, RT_JUMP, 8'h00, 1, 8'h02, 0, 8'h22, 8'h01, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h33, 8'h02, 0, 0, 0));
        // late ack, then decoder stalls two cycles
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 1, 8'h03, 0, 8'h33, 8'h02, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 1, 8'h03, 0, 8'h33, 8'h02, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 1, 8'h03, 0, 8'h33, 8'h02, 0, 0, 0));
        tv.push_back(mk(1, 8'h44, 0, 0, RT_JUMP, 8'h00, 1, 8'h03, 0, 8'h33, 8'h02, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h44, 8'h03, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h44, 8'h03, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h44, 8'h03, 0, 0, 0));
        // JUMP 40 with read outstanding: flush, a redirect during flush is ignored
        tv.push_back(mk(0, 8'h00, 0, 1, RT_JUMP, 8'h40, 1, 8'h04, 0, 8'h44, 8'h03, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, RT_JUMP, 8'h99, 0, 8'h00, 0, 8'h44, 8'h03, 0, 0, 0));
        tv.push_back(mk(1, 8'h55, 0, 0, RT_JUMP, 8'h00, 0, 8'h00, 0, 8'h44, 8'h03, 0, 0, 0));
        tv.push_back(mk(1, 8'h66, 0, 0, RT_JUMP, 8'h00, 1, 8'h40, 0, 8'h44, 8'h03, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h66, 8'h40, 0, 0, 0));
        // JUMP 10 with ack in the same cycle goes straight back to REQ
        tv.push_back(mk(1, 8'h77, 0, 1, RT_JUMP, 8'h10, 1, 8'h41, 0, 8'h66, 8'h40, 0, 0, 0));
        tv.push_back(mk(1, 8'h88, 0, 0, RT_JUMP, 8'h00, 1, 8'h10, 0, 8'h66, 8'h40, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'h88, 8'h10, 0, 0, 0));
        tv.push_back(mk(1, 8'h99, 0, 0, RT_JUMP, 8'h00, 1, 8'h11, 0, 8'h88, 8'h10, 0, 0, 0));
        // CALL 80 (pushes 11), CALL C0 (pushes 81), RET, RET
        tv.push_back(mk(0, 8'h00, 1, 1, RT_CALL, 8'h80, 0, 8'h00, 1, 8'h99, 8'h11, 0, 0, 0));
        tv.push_back(mk(1, 8'hA0, 0, 0, RT_JUMP, 8'h00, 1, 8'h80, 0, 8'h99, 8'h11, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'hA0, 8'h80, 1, 0, 0));
        tv.push_back(mk(1, 8'hA1, 0, 0, RT_JUMP, 8'h00, 1, 8'h81, 0, 8'hA0, 8'h80, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, RT_CALL, 8'hC0, 0, 8'h00, 1, 8'hA1, 8'h81, 1, 0, 0));
        tv.push_back(mk(1, 8'hB0, 0, 0, RT_JUMP, 8'h00, 1, 8'hC0, 0, 8'hA1, 8'h81, 2, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, RT_RET,  8'h00, 0, 8'h00, 1, 8'hB0, 8'hC0, 2, 0, 0));
        tv.push_back(mk(1, 8'hB1, 0, 0, RT_JUMP, 8'h00, 1, 8'h81, 0, 8'hB0, 8'hC0, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, RT_RET,  8'h00, 0, 8'h00, 1, 8'hB1, 8'h81, 1, 0, 0));
        tv.push_back(mk(1, 8'hC1, 0, 0, RT_JUMP, 8'h00, 1, 8'h11, 0, 8'hB1, 8'h81, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, RT_JUMP, 8'h00, 0, 8'h00, 1, 8'hC1, 8'h11, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, RT_JUMP, 8'h00, 1, 8'h12, 0, 8'hC1, 8'h11, 0, 0, 0));

        areset = 1'b1; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
        redir_valid = 1'b0; redir_type = RT_JUMP; redir_target = '0;

        do_reset;
        check("reset outputs", 64'(outs()), 64'd0);

        foreach (tv[i]) begin
            cyc(0, tv[i].ack, tv[i].data, tv[i].rdy, tv[i].rv, tv[i].rt, tv[i].tgt);
            check($sformatf("row %0d {req,addr,vld,instr,ipc,cnt,err,halt}", i), 64'(outs()),
                  64'({tv[i].req, tv[i].addr, tv[i].vld, tv[i].ins, tv[i].ipc,
                       tv[i].cnt, tv[i].err, tv[i].hlt}));
        end

        // Overflow: five CALLs into a 4-deep stack, then drain and RET on empty.
        do_reset;
        cyc(0, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        cyc(0, 1, 8'h00, 0, 0, RT_JUMP, 8'h00);
        check("ovf first addr", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));
        cyc(0, 0, 8'h00, 1, 0, RT_JUMP, 8'h00);
        exp_addr = 8'h01;
        for (int k = 0; k < 5; k++) begin
            tgt = 8'h30 + 8'(k * 16);
            cyc(0, 1, 8'h00, 0, 1, RT_CALL, tgt);
            check($sformatf("ovf call %0d {req,addr,cnt}", k), 64'({imem_req, imem_addr, rs_count}),
                  64'({1'b1, exp_addr, 3'((k > 4) ? 4 : k)}));
            cyc(0, 1, 8'hD0, 0, 0, RT_JUMP, 8'h00);
            check($sformatf("ovf target %0d {addr,cnt,err}", k), 64'({imem_addr, rs_count, rs_err}),
                  64'({tgt, 3'((k + 1 > 4) ? 4 : k + 1), (k == 4)}));
            cyc(0, 0, 8'h00, 1, 0, RT_JUMP, 8'h00);
            exp_addr = tgt + 8'h01;
        end
        pops[0] = 8'h61; pops[1] = 8'h51; pops[2] = 8'h41; pops[3] = 8'h31; pops[4] = 8'h20;
        for (int j = 0; j < 5; j++) begin
            cyc(0, 1, 8'h00, 0, 1, RT_RET, 8'h20);
            check($sformatf("ret %0d {req,addr,cnt,err}", j),
                  64'({imem_req, imem_addr, rs_count, rs_err}),
                  64'({1'b1, exp_addr, 3'(4 - j), 1'b1}));
            exp_addr = pops[j];
        end
        cyc(0, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        check("empty ret {addr,cnt,err}", 64'({imem_addr, rs_count, rs_err}),
              64'({8'h20, 3'd0, 1'b1}));

        // PC wrap at FF, HALT through FLUSH, then reset during ISSUE.
        do_reset;
        cyc(0, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        cyc(0, 1, 8'h00, 0, 1, RT_JUMP, 8'hFF);
        cyc(0, 1, 8'hE0, 0, 0, RT_JUMP, 8'h00);
        check("wrap fetch FF", 64'({imem_req, imem_addr}), 64'({1'b1, 8'hFF}));
        cyc(0, 0, 8'h00, 1, 0, RT_JUMP, 8'h00);
        check("wrap issue {vld,instr,ipc}", 64'({instr_valid, instr, instr_pc}),
              64'({1'b1, 8'hE0, 8'hFF}));
        cyc(0, 0, 8'h00, 0, 1, RT_HALT, 8'h00);
        check("wrap next addr", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));
        cyc(0, 1, 8'h00, 0, 0, RT_JUMP, 8'h00);
        check("halt flush {req,vld,halted}", 64'({imem_req, instr_valid, halted}), 64'd0);
        cyc(0, 1, 8'h00, 1, 1, RT_JUMP, 8'h33);
        check("halted {req,vld,halted}", 64'({imem_req, instr_valid, halted}), 64'b001);
        cyc(1, 1, 8'h00, 1, 0, RT_JUMP, 8'h00);
        check("halt sticky {req,vld,halted}", 64'({imem_req, instr_valid, halted}), 64'b001);
        cyc(0, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        check("halt exit by reset", 64'(outs()), 64'd0);
        cyc(0, 1, 8'h00, 0, 1, RT_JUMP, 8'h55);
        cyc(0, 1, 8'h5A, 0, 0, RT_JUMP, 8'h00);
        cyc(1, 0, 8'h00, 1, 0, RT_JUMP, 8'h00);
        check("pre-reset issue {vld,instr,ipc}", 64'({instr_valid, instr, instr_pc}),
              64'({1'b1, 8'h5A, 8'h55}));
        cyc(0, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        check("reset mid-issue", 64'(outs()), 64'd0);
        cyc(0, 0, 8'h00, 0, 0, RT_JUMP, 8'h00);
        check("after reset addr", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
